keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, clock cycles each column is driven during scanning (legal range >= 4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive stable cycles required to accept a press or release (legal range >= 2).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 row  input  4  raw keypad row sense lines, active-high, asynchronous to clk; row[3] is R0 and row[0] is R3.
REQ-006 col  output  4  one-hot column drive, active-high; col[3] is C0 and col[0] is C3.
REQ-007 strobe  output  1  one-cycle pulse marking a newly accepted key press.
REQ-008 cur_key  output  8  {row one-hot, col one-hot} of the last accepted key; for example, R2 C0 = 8'b0010_1000.
REQ-009 key_held  output  1  high while an accepted key remains pressed, before its release is confirmed.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer; all decisions use only the synchronized value (rs).
REQ-011 The FSM SHALL have exactly four states: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-012 SCAN: col SHALL rotate C0->C1->C2->C3->C0, holding each column SCAN_DIV cycles; rs SHALL be sampled only in the last cycle of each dwell.
REQ-013 SCAN, sample with rs != 0: the module SHALL latch {rs, col} as the candidate key, freeze col, clear the debounce counter, and go to DEBOUNCE.
REQ-014 DEBOUNCE: the counter SHALL increment each cycle that rs equals the candidate row.
  - Any mismatch: return to SCAN, resuming at the next column, with no strobe.
  - Counter reaches DEBOUNCE_CYCLES-1: next cycle, cur_key <= candidate, strobe=1 for exactly one cycle, state -> PRESSED.
REQ-015 PRESSED: col SHALL stay frozen and key_held=1.
  - Candidate row bit low in rs: go to RELEASE with the counter cleared.
  - Additional row bits rising: ignored.
REQ-016 RELEASE: key_held SHALL remain 1.
  - Candidate row bit high again: return to PRESSED with no new strobe.
  - DEBOUNCE_CYCLES consecutive low cycles: go to SCAN at the next column, with key_held=0.
REQ-017 cur_key SHALL change only in the strobe cycle and otherwise hold its value; it is valid in the strobe cycle itself.
REQ-018 strobe SHALL never be asserted in two consecutive cycles; at most one strobe per physical press, regardless of hold duration.
REQ-019 Counters SHALL be sized $clog2 of their parameter and SHALL never wrap; scan column index wrap C3->C0 is the only wrap-around.
REQ-020 Press latency from a stable rs to strobe SHALL be at most 4*SCAN_DIV + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-021 While rst=1, regardless of clock: state=SCAN, col=4'b1000 (C0), scan and debounce counters=0, synchronizer flops=0, strobe=0, key_held=0, cur_key=8'd0.
REQ-022 Reset asserted mid-debounce or mid-press SHALL discard the candidate with no strobe; scanning restarts at C0 with a full dwell after deassertion.

Configuration
REQ-023 Macro KEYPAD_MULTI_KEY_REJECT_EN:
  - Defined: a SCAN sample with more than one bit set in rs SHALL be ignored (no latch, scanning continues).
  - Defined: in DEBOUNCE, rs gaining a second bit counts as a mismatch.
  - Undefined: on multiple set bits, the lowest row index (highest-order rs bit) SHALL be taken as the candidate and other bits ignored.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-024 Hold R2 C0 pressed for 200 cycles -> exactly one strobe, cur_key=8'b0010_1000, key_held high until 8 low cycles after release.
REQ-025 Bounce R3 C1 for 3 high cycles then low, three times, then stable high -> one strobe only after the stable phase, cur_key=8'b0001_0100.
REQ-026 Press R0 C3, release, press again -> two strobes, each cur_key=8'b1000_0001; a 3-cycle release glitch while held produces no extra strobe.
REQ-027 R1 and R2 pressed together in C2:
  - KEYPAD_MULTI_KEY_REJECT_EN defined -> no strobe.
  - Undefined -> strobe with cur_key=8'b0100_0010.
REQ-028 Assert rst at debounce count 5 -> no strobe, all outputs at reset values, col=4'b1000 for the first 4 cycles after deassertion.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: row sense in, column drive and key report out.
// master = scanner side, slave = keypad/consumer side.
`timescale 1ns/1ps
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic       strobe;
    logic [7:0] cur_key;
    logic       key_held;

    modport master (input row, output col, output strobe, output cur_key, output key_held);
    modport slave  (output row, input col, input strobe, input cur_key, input key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column rotation, debounced press/release, one-cycle strobe per press.
// Optional macro KEYPAD_MULTI_KEY_REJECT_EN rejects samples with more than one row active.
`timescale 1ns/1ps
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);
    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_t;

    state_t        state_q;
    logic [3:0]    row_meta_q;
    logic [3:0]    rs;
    logic [SW-1:0] scan_cnt_q;
    logic [DW-1:0] deb_cnt_q;
    logic [3:0]    col_q;
    logic [3:0]    cand_row_q;
    logic [7:0]    cur_key_q;
    logic          strobe_q;
    logic          key_held_q;

    logic [3:0] rs_pick;
    logic       rs_ok;
    logic       cand_match;
    logic       cand_high;
    logic [3:0] col_next;

`ifdef KEYPAD_MULTI_KEY_REJECT_EN
    assign rs_pick    = rs;
    assign rs_ok      = (rs != 4'd0) && ((rs & (rs - 4'd1)) == 4'd0);
    assign cand_match = (rs == cand_row_q);
`else
    // Lowest row index (highest-order bit) wins; other rows are ignored.
    assign rs_pick    = rs[3] ? 4'b1000 :
                        rs[2] ? 4'b0100 :
                        rs[1] ? 4'b0010 : {3'b000, rs[0]};
    assign rs_ok      = |rs;
    assign cand_match = |(rs & cand_row_q);
`endif

    assign cand_high = |(rs & cand_row_q);
    assign col_next  = {col_q[0], col_q[3:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= 4'd0;
            rs         <= 4'd0;
        end else begin
            row_meta_q <= kp.row;
            rs         <= row_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StScan;
            scan_cnt_q <= '0;
            deb_cnt_q  <= '0;
            col_q      <= 4'b1000;
            cand_row_q <= 4'd0;
            cur_key_q  <= 8'd0;
            strobe_q   <= 1'b0;
            key_held_q <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            unique case (state_q)
                StScan: begin
                    if (scan_cnt_q == SCAN_LAST) begin
                        scan_cnt_q <= '0;
                        if (rs_ok) begin
                            cand_row_q <= rs_pick;
                            deb_cnt_q  <= '0;
                            state_q    <= StDebounce;
                        end else begin
                            col_q <= col_next;
                        end
                    end else begin
                        scan_cnt_q <= scan_cnt_q + SW'(1);
                    end
                end
                StDebounce: begin
                    if (!cand_match) begin
                        col_q   <= col_next;
                        state_q <= StScan;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        cur_key_q  <= {cand_row_q, col_q};
                        strobe_q   <= 1'b1;
                        key_held_q <= 1'b1;
                        state_q    <= StPressed;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DW'(1);
                    end
                end
                StPressed: begin
                    if (!cand_high) begin
                        deb_cnt_q <= '0;
                        state_q   <= StRelease;
                    end
                end
                StRelease: begin
                    if (cand_high) begin
                        state_q <= StPressed;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        key_held_q <= 1'b0;
                        col_q      <= col_next;
                        state_q    <= StScan;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DW'(1);
                    end
                end
                default: state_q <= StScan;
            endcase
        end
    end

    assign kp.col      = col_q;
    assign kp.strobe   = strobe_q;
    assign kp.cur_key  = cur_key_q;
    assign kp.key_held = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed scenarios and randomized presses.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int SD      = 4;
    localparam int DB      = 8;
    localparam int LAT_MAX = 4 * SD + DB + 1 + 3; // +2 synchronizer, +1 sampling slack

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0; // contact closed for key (r,c) at bit r*4+c
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          strobes = 0;
    int          last_strobe_cyc = 0;
    logic        prev_strobe = 1'b0;
    logic [7:0]  prev_key = 8'd0;

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Matrix: a closed key connects its row line to its driven column.
    always_comb begin
        kp.row = 4'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && kp.col[3-c]) kp.row[3-r] = 1'b1;
    end

    function automatic logic [7:0] key_code(input int r, input int c);
        return (8'h80 >> r) | (8'h08 >> c);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (kp.strobe === 1'b1) begin
                strobes++;
                last_strobe_cyc = cyc;
                check("no_back_to_back_strobe", 32'(prev_strobe), 32'd0);
            end
            if (kp.cur_key !== prev_key)
                check("key_change_only_on_strobe", 32'(kp.strobe), 32'd1);
        end
        prev_strobe = kp.strobe;
        prev_key    = kp.cur_key;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input int r, input int c, input int hold, input string tag);
        int s0;
        int t0;
        s0 = strobes;
        t0 = cyc;
        keys[r*4+c] = 1'b1;
        repeat (hold) step();
        check({tag, "_strobes"}, 32'(strobes - s0), 32'd1);
        check({tag, "_latency_ok"}, 32'((last_strobe_cyc - t0) <= LAT_MAX), 32'd1);
        check({tag, "_cur_key"}, 32'(kp.cur_key), 32'(key_code(r, c)));
        check({tag, "_held"}, 32'(kp.key_held), 32'd1);
    endtask

    task automatic release_and_wait(input string tag);
        int n;
        keys = '0;
        repeat (DB) step();
        check({tag, "_held_during_release"}, 32'(kp.key_held), 32'd1);
        n = 0;
        while (kp.key_held === 1'b1 && n < 30) begin
            step();
            n++;
        end
        check({tag, "_held_cleared"}, 32'(kp.key_held), 32'd0);
    endtask

    initial begin
        int s0;
        int r;
        int c;
        int nb;

        // Reset values
        repeat (2) step();
        check("rst_col", 32'(kp.col), 32'h8);
        check("rst_strobe", 32'(kp.strobe), 32'd0);
        check("rst_held", 32'(kp.key_held), 32'd0);
        check("rst_cur_key", 32'(kp.cur_key), 32'd0);
        rst = 1'b0;
        step();

        // R2 C0 held 200 cycles
        press(2, 0, 200, "r2c0");
        release_and_wait("r2c0");

        // R3 C1 bounces three times before settling
        s0 = strobes;
        repeat (3) begin
            keys[13] = 1'b1;
            repeat (3) step();
            keys[13] = 1'b0;
            repeat ($urandom_range(10, 4)) step();
        end
        check("bounce_no_early_strobe", 32'(strobes - s0), 32'd0);
        press(3, 1, 60, "r3c1");
        release_and_wait("r3c1");

        // R0 C3 twice, with a short release glitch during the second hold
        press(0, 3, 60, "r0c3_first");
        release_and_wait("r0c3_first");
        press(0, 3, 60, "r0c3_second");
        s0 = strobes;
        keys[3] = 1'b0;
        repeat (3) begin
            step();
            check("glitch_held", 32'(kp.key_held), 32'd1);
        end
        keys[3] = 1'b1;
        repeat (40) step();
        check("glitch_no_strobe", 32'(strobes - s0), 32'd0);
        check("glitch_cur_key", 32'(kp.cur_key), 32'h81);
        release_and_wait("r0c3_second");

        // Randomized single-key presses with optional pre-bounce
        for (int i = 0; i < 6; i++) begin
            r  = int'($urandom_range(3, 0));
            c  = int'($urandom_range(3, 0));
            nb = int'($urandom_range(2, 0));
            s0 = strobes;
            for (int b = 0; b < nb; b++) begin
                keys[r*4+c] = 1'b1;
                repeat ($urandom_range(3, 1)) step();
                keys[r*4+c] = 1'b0;
                repeat ($urandom_range(8, 4)) step();
            end
            check("rand_bounce_no_strobe", 32'(strobes - s0), 32'd0);
            press(r, c, int'($urandom_range(80, LAT_MAX + 5)), "rand");
            release_and_wait("rand");
        end

        // R1 and R2 together in C2
        s0 = strobes;
        keys[6]  = 1'b1;
        keys[10] = 1'b1;
        repeat (100) step();
`ifdef KEYPAD_MULTI_KEY_REJECT_EN
        check("multi_rejected_strobes", 32'(strobes - s0), 32'd0);
        check("multi_rejected_held", 32'(kp.key_held), 32'd0);
        keys = '0;
        repeat (20) step();
`else
        check("multi_strobes", 32'(strobes - s0), 32'd1);
        check("multi_cur_key", 32'(kp.cur_key), 32'h42);
        check("multi_held", 32'(kp.key_held), 32'd1);
        release_and_wait("multi");
`endif

        // Reset at debounce count 5 discards the candidate
        rst = 1'b1;
        keys[4] = 1'b1; // R1 C0, visible from the first dwell after reset
        repeat (3) step();
        rst = 1'b0;
        s0 = strobes;
        repeat (9) step();
        check("mid_deb_col_frozen", 32'(kp.col), 32'h8);
        rst = 1'b1;
        #1;
        check("mid_deb_rst_strobe", 32'(kp.strobe), 32'd0);
        check("mid_deb_rst_held", 32'(kp.key_held), 32'd0);
        check("mid_deb_rst_cur_key", 32'(kp.cur_key), 32'd0);
        check("mid_deb_rst_col", 32'(kp.col), 32'h8);
        keys = '0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        check("post_rst_col_0", 32'(kp.col), 32'h8);
        for (int k = 1; k < 4; k++) begin
            step();
            check("post_rst_col_dwell", 32'(kp.col), 32'h8);
        end
        step();
        check("post_rst_col_rotate", 32'(kp.col), 32'h4);
        repeat (40) step();
        check("post_rst_no_strobe", 32'(strobes - s0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
